// File: rtl/alu_issue_ctrl_if.sv
// Interface bundling the decoder request, ALU bus and completion outputs of alu_issue_ctrl.
// The master side is the decoder/ALU environment; the slave side is the issue controller.
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       shamt;
  logic [15:0]      imm;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_aluc;
  logic [WIDTH-1:0] alu_r;
  logic             alu_zero;
  logic             alu_carry;
  logic             alu_negative;
  logic             alu_overflow;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             result_we;
  logic             branch_taken;
  logic             ovf_exc;
  logic             illegal;
  logic [3:0]       flags;

  modport master (
    output start, opcode, funct, shamt, imm, rs_val, rt_val,
    output alu_r, alu_zero, alu_carry, alu_negative, alu_overflow,
    input  alu_a, alu_b, alu_aluc,
    input  busy, done, result, result_we, branch_taken, ovf_exc, illegal, flags
  );

  modport slave (
    input  start, opcode, funct, shamt, imm, rs_val, rt_val,
    input  alu_r, alu_zero, alu_carry, alu_negative, alu_overflow,
    output alu_a, alu_b, alu_aluc,
    output busy, done, result, result_we, branch_taken, ovf_exc, illegal, flags
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Multicycle MIPS ALU issue sequencer: IDLE -> DECODE -> EXEC -> WB, one instruction per handshake.
// Completion outputs are registered on WB exit, so done appears three edges after the accept edge.
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave bus
);

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;
  localparam logic [3:0] ALUC_LUI  = 4'b1000;
  localparam logic [3:0] ALUC_SLTU = 4'b1010;
  localparam logic [3:0] ALUC_SLT  = 4'b1011;
  localparam logic [3:0] ALUC_SRA  = 4'b1100;
  localparam logic [3:0] ALUC_SRL  = 4'b1101;
  localparam logic [3:0] ALUC_SLL  = 4'b1110;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [5:0]       r_opcode;
  logic [5:0]       r_funct;
  logic [4:0]       r_shamt;
  logic [15:0]      r_imm;
  logic [WIDTH-1:0] r_rsVal;
  logic [WIDTH-1:0] r_rtVal;
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic [3:0]       r_aluc;
  logic [WIDTH-1:0] r_aluR;
  logic [3:0]       r_flags;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_resultWe;
  logic             r_branchTaken;
  logic             r_ovfExc;
  logic             r_illegal;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [3:0]       w_aluc;
  logic             w_illegal;
  logic             w_isBeq;
  logic             w_isBne;
  logic             w_chkAdd;
  logic             w_chkSub;
  logic             w_ovf;
  logic [WIDTH-1:0] w_signExt;
  logic [WIDTH-1:0] w_zeroExt;
  logic [WIDTH-1:0] w_shamtExt;
  logic [WIDTH-1:0] w_rsShExt;

  assign w_signExt  = {{(WIDTH-16){r_imm[15]}}, r_imm};
  assign w_zeroExt  = {{(WIDTH-16){1'b0}}, r_imm};
  assign w_shamtExt = {{(WIDTH-5){1'b0}}, r_shamt};
  assign w_rsShExt  = {{(WIDTH-5){1'b0}}, r_rsVal[4:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = DECODE;
      DECODE:  w_nextState = EXEC;
      EXEC:    w_nextState = WB;
      WB:      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Decode works from the captured fields, so it stays valid through WB for classification.
  always_comb begin
    w_a       = '0;
    w_b       = '0;
    w_aluc    = ALUC_ADDU;
    w_illegal = 1'b0;
    w_isBeq   = 1'b0;
    w_isBne   = 1'b0;
    w_chkAdd  = 1'b0;
    w_chkSub  = 1'b0;
    case (r_opcode)
      6'b000000: begin
        w_a = r_rsVal;
        w_b = r_rtVal;
        case (r_funct)
          6'b100000: begin w_aluc = ALUC_ADD; w_chkAdd = 1'b1; end
          6'b100001: w_aluc = ALUC_ADDU;
          6'b100010: begin w_aluc = ALUC_SUB; w_chkSub = 1'b1; end
          6'b100011: w_aluc = ALUC_SUBU;
          6'b100100: w_aluc = ALUC_AND;
          6'b100101: w_aluc = ALUC_OR;
          6'b100110: w_aluc = ALUC_XOR;
          6'b100111: w_aluc = ALUC_NOR;
          6'b101010: w_aluc = ALUC_SLT;
          6'b101011: w_aluc = ALUC_SLTU;
          6'b000000: begin w_aluc = ALUC_SLL; w_a = w_shamtExt; end
          6'b000010: begin w_aluc = ALUC_SRL; w_a = w_shamtExt; end
          6'b000011: begin w_aluc = ALUC_SRA; w_a = w_shamtExt; end
          6'b000100: begin w_aluc = ALUC_SLL; w_a = w_rsShExt; end
          6'b000110: begin w_aluc = ALUC_SRL; w_a = w_rsShExt; end
          6'b000111: begin w_aluc = ALUC_SRA; w_a = w_rsShExt; end
          default: begin
            w_illegal = 1'b1;
            w_a       = '0;
            w_b       = '0;
          end
        endcase
      end
      6'b001000: begin w_aluc = ALUC_ADD;  w_a = r_rsVal; w_b = w_signExt; w_chkAdd = 1'b1; end
      6'b001001: begin w_aluc = ALUC_ADDU; w_a = r_rsVal; w_b = w_signExt; end
      6'b001010: begin w_aluc = ALUC_SLT;  w_a = r_rsVal; w_b = w_signExt; end
      6'b001011: begin w_aluc = ALUC_SLTU; w_a = r_rsVal; w_b = w_signExt; end
      6'b001100: begin w_aluc = ALUC_AND;  w_a = r_rsVal; w_b = w_zeroExt; end
      6'b001101: begin w_aluc = ALUC_OR;   w_a = r_rsVal; w_b = w_zeroExt; end
      6'b001110: begin w_aluc = ALUC_XOR;  w_a = r_rsVal; w_b = w_zeroExt; end
      6'b001111: begin w_aluc = ALUC_LUI;  w_b = w_zeroExt; end
      6'b000100: begin w_aluc = ALUC_SUBU; w_a = r_rsVal; w_b = r_rtVal; w_isBeq = 1'b1; end
      6'b000101: begin w_aluc = ALUC_SUBU; w_a = r_rsVal; w_b = r_rtVal; w_isBne = 1'b1; end
      default:   w_illegal = 1'b1;
    endcase
  end

  // Signed overflow judged from the issued operands and the sampled result, not the ALU's flag.
  always_comb begin
    w_ovf = 1'b0;
    if (w_chkAdd)
      w_ovf = (r_aluA[WIDTH-1] == r_aluB[WIDTH-1]) && (r_aluR[WIDTH-1] != r_aluA[WIDTH-1]);
    else if (w_chkSub)
      w_ovf = (r_aluA[WIDTH-1] != r_aluB[WIDTH-1]) && (r_aluR[WIDTH-1] != r_aluA[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode      <= '0;
      r_funct       <= '0;
      r_shamt       <= '0;
      r_imm         <= '0;
      r_rsVal       <= '0;
      r_rtVal       <= '0;
      r_aluA        <= '0;
      r_aluB        <= '0;
      r_aluc        <= ALUC_ADDU;
      r_aluR        <= '0;
      r_flags       <= '0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_resultWe    <= 1'b0;
      r_branchTaken <= 1'b0;
      r_ovfExc      <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_opcode <= bus.opcode;
            r_funct  <= bus.funct;
            r_shamt  <= bus.shamt;
            r_imm    <= bus.imm;
            r_rsVal  <= bus.rs_val;
            r_rtVal  <= bus.rt_val;
          end
        end
        DECODE: begin
          r_aluA <= w_a;
          r_aluB <= w_b;
          r_aluc <= w_aluc;
        end
        EXEC: begin
          r_aluR  <= bus.alu_r;
          r_flags <= {bus.alu_zero, bus.alu_carry, bus.alu_negative, bus.alu_overflow};
        end
        WB: begin
          r_done        <= 1'b1;
          r_result      <= r_aluR;
          r_resultWe    <= !w_illegal && !w_isBeq && !w_isBne && !w_ovf;
          r_branchTaken <= (w_isBeq && r_flags[3]) || (w_isBne && !r_flags[3]);
          r_ovfExc      <= w_ovf;
          r_illegal     <= w_illegal;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (r_state != IDLE);
  assign bus.done         = r_done;
  assign bus.result       = r_result;
  assign bus.result_we    = r_resultWe;
  assign bus.branch_taken = r_branchTaken;
  assign bus.ovf_exc      = r_ovfExc;
  assign bus.illegal      = r_illegal;
  assign bus.flags        = r_flags;
  assign bus.alu_a        = r_aluA;
  assign bus.alu_b        = r_aluB;
  assign bus.alu_aluc     = r_aluc;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multicycle issue sequencer that drives the ALU interface (operands a/b, 4-bit aluc) and consumes its result and flags (zero/carry/negative/overflow). It accepts one decoded MIPS instruction per handshake, maps opcode/funct to an aluc code and operands, then samples the ALU result. It produces the write-back value, branch decision, overflow exception and a latched flag word for the control unit. It sits between the instruction decoder and the ALU in the multicycle non-pipelined datapath.

Parameters:
WIDTH, 32, datapath width. Only 32 is supported.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
opcode  in  6  instruction[31:26]
funct  in  6  instruction[5:0]
shamt  in  5  instruction[10:6]
imm  in  16  instruction[15:0]
rs_val  in  32  GPR[rs]
rt_val  in  32  GPR[rt]
alu_a  out  32  ALU operand a
alu_b  out  32  ALU operand b
alu_aluc  out  4  ALU control code
alu_r  in  32  ALU result
alu_zero, alu_carry, alu_negative, alu_overflow  in  1 each  ALU flags
busy  out  1  high from accept until done
done  out  1  one-cycle completion pulse
result  out  32  write-back value
result_we  out  1  write-back enable, valid with done
branch_taken  out  1  valid with done
ovf_exc  out  1  signed-overflow exception, valid with done
illegal  out  1  unsupported encoding, valid with done
flags  out  4  {zero,carry,negative,overflow} latched at EXEC

Behaviour:
- Reset values (async, rst_n=0): state IDLE; busy, done, result_we, branch_taken, ovf_exc, illegal = 0; result, flags, alu_a, alu_b = 0; alu_aluc = 4'b0000.
- FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE: start=1 captures all inputs and sets busy=1. start is ignored when busy=1.
- DECODE: registers alu_a, alu_b and alu_aluc from the captured fields.
- EXEC: ALU output is stable. Samples alu_r and the flags into internal registers and flags.
- WB: done=1 for exactly one cycle with result, result_we, branch_taken, ovf_exc and illegal. busy drops when WB exits. Outputs hold until the next WB. done is not asserted at any other time.
- Latency: done is asserted 3 cycles after the accept edge. Back-to-back: start may be asserted in the cycle after WB, giving 4 cycles per instruction.
- aluc codes: ADDU 0000, SUBU 0001, ADD 0010, SUB 0011, AND 0100, OR 0101, XOR 0110, NOR 0111, LUI 1000, SLTU 1010, SLT 1011, SRA 1100, SRL 1101, SLL 1110.
- R-type (opcode 000000), by funct:
  - add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, xor 100110, nor 100111, slt 101010, sltu 101011: a=rs_val, b=rt_val.
  - sll 000000, srl 000010, sra 000011: a={27'b0,shamt}, b=rt_val.
  - sllv 000100, srlv 000110, srav 000111: a={27'b0,rs_val[4:0]}, b=rt_val.
- I-type:
  - addi 001000 (ADD), addiu 001001 (ADDU), slti 001010 (SLT), sltiu 001011 (SLTU): b=sign-extended imm.
  - andi 001100, ori 001101, xori 001110: b=zero-extended imm.
  - lui 001111 (LUI): a=0, b={16'b0,imm}.
  - beq 000100, bne 000101: SUBU, a=rs_val, b=rt_val, result_we=0.
- Branches: branch_taken = alu_zero for beq, !alu_zero for bne. It is 0 for all other instructions.
- Overflow: computed locally; alu_overflow is not used for this decision.
  - ADD/ADDI: ovf = (a[31]==b[31]) && (r[31]!=a[31]).
  - SUB: ovf = (a[31]!=b[31]) && (r[31]!=a[31]).
  - On ovf: ovf_exc=1, result_we=0, result=alu_r.
  - ADDU/ADDIU/SUBU never raise ovf_exc.
- Illegal encoding: drives aluc ADDU with a=b=0, still completes in WB. Sets illegal=1, result_we=0, branch_taken=0.
- result_we=1 for every legal non-branch instruction without overflow.
- Reset mid-operation: immediate return to IDLE with reset values. No done pulse for the aborted instruction.

Test Plan:
- Reset: rst_n=0 in EXEC of an add -> all outputs at reset values immediately. After release, no done pulse until the next start.
- addu, rs=0xFFFFFFFF, rt=1: aluc=0000, result=0, result_we=1, ovf_exc=0, flags[3]=1, done exactly 3 cycles after accept. Same operands with add: ovf_exc=0.
- add, rs=0x7FFFFFFF, rt=1: aluc=0010, ovf_exc=1, result_we=0, result=0x80000000. sub, rs=0x80000000, rt=1: ovf_exc=1.
- addi with imm=0xFFFF, rs=5: b=0xFFFFFFFF, result=4. ori with imm=0xFFFF, rs=0: b=0x0000FFFF, result=0x0000FFFF. lui imm=0x1234: result=0x12340000.
- beq, rs=rt=0xA5: branch_taken=1, result_we=0. bne with the same operands: branch_taken=0. slt, rs=-1, rt=1: result=1. sltu with the same operands: result=0.
- sra shamt=4, rt=0x80000000: result=0xF8000000. srlv rs=36, rt=0x80000000: a=4, result=0x08000000.
- Handshake: hold start=1 continuously -> accepts only in IDLE, one done per 4 cycles. opcode=111111 -> illegal=1, result_we=0.
